// File: rtl/bp_pkg.sv
// bp_pkg: BTB entry layout, index/tag extraction and saturating-counter helpers.
package bp_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
      logic [3:0]  cnt;
   } bp_entry_t;

   function automatic logic [31:0] low_mask(int w);
      return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic [31:0] idx_of(logic [31:0] pc, int idx_w);
      return (pc >> 2) & low_mask(idx_w);
   endfunction

   function automatic logic [31:0] tag_of(logic [31:0] pc, int idx_w, int tag_w);
      return (pc >> (idx_w + 2)) & low_mask(tag_w);
   endfunction

   function automatic logic [3:0] wnt(int cnt_w);
      return 4'((5'd1 << (cnt_w - 1)) - 5'd1);
   endfunction

   function automatic logic [3:0] wt(int cnt_w);
      return 4'(5'd1 << (cnt_w - 1));
   endfunction

   function automatic logic [3:0] cnt_max(int cnt_w);
      return 4'((5'd1 << cnt_w) - 5'd1);
   endfunction

   function automatic logic [3:0] sat_step(logic [3:0] cnt, logic up, int cnt_w);
      return up ? ((cnt == cnt_max(cnt_w)) ? cnt : cnt + 4'd1)
                : ((cnt == 4'd0) ? cnt : cnt - 4'd1);
   endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: IF lookup, EX update/recovery and perf signals between pipeline and predictor.
interface branch_predictor_if #(parameter int PERF_W = 32);
   logic [31:0]       if_pc;
   logic              pred_hit;
   logic              pred_taken;
   logic [31:0]       pred_next_pc;
   logic              upd_valid;
   logic [31:0]       upd_pc;
   logic              upd_taken;
   logic [31:0]       upd_target;
   logic              upd_pred_taken;
   logic [31:0]       upd_pred_target;
   logic              mispredict;
   logic [31:0]       recover_pc;
   logic [PERF_W-1:0] perf_branches;
   logic [PERF_W-1:0] perf_mispred;
   modport master (
      output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
      input  pred_hit, pred_taken, pred_next_pc, mispredict, recover_pc, perf_branches, perf_mispred
   );
   modport slave (
      input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
      output pred_hit, pred_taken, pred_next_pc, mispredict, recover_pc, perf_branches, perf_mispred
   );
endinterface

// File: rtl/bp_table.sv
// bp_table: direct-mapped BTB storage; combinational lookup and update-side reads, one write port.
module bp_table
   import bp_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4,
   parameter int CNT_W   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output bp_entry_t        rd_entry,
   input  logic [IDX_W-1:0] up_idx,
   output bp_entry_t        up_entry,
   input  logic             wr_en,
   input  bp_entry_t        wr_entry
);
   bp_entry_t mem [ENTRIES];
   assign rd_entry = mem[rd_idx];
   assign up_entry = mem[up_idx];
   // The update always rewrites the entry it just read, so the write shares up_idx.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++)
            mem[i] <= bp_entry_t'{valid: 1'b0, tag: '0, target: '0, cnt: wnt(CNT_W)};
      end else if (wr_en) begin
         mem[up_idx] <= wr_entry;
      end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB with saturating counters; zero-latency IF lookup, EX-stage training,
// mispredict detection with recovery PC and saturating performance counters.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int CNT_W   = 2,
   parameter int PERF_W  = 32
) (
   input logic               clk,
   input logic               reset,
   branch_predictor_if.slave bp
);
   localparam int IDX_W = $clog2(ENTRIES);
   bp_entry_t rd_e, up_e, wr_e;
   logic [IDX_W-1:0] if_idx, up_idx;
   logic [31:0] if_tag, up_tag;
   logic up_hit, wr_en, mis;
   logic [PERF_W-1:0] n_br, n_mis;
   assign if_idx = IDX_W'(idx_of(bp.if_pc, IDX_W));
   assign up_idx = IDX_W'(idx_of(bp.upd_pc, IDX_W));
   assign if_tag = tag_of(bp.if_pc, IDX_W, TAG_W);
   assign up_tag = tag_of(bp.upd_pc, IDX_W, TAG_W);
   bp_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_table (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (if_idx),
      .rd_entry (rd_e),
      .up_idx   (up_idx),
      .up_entry (up_e),
      .wr_en    (wr_en),
      .wr_entry (wr_e)
   );
   assign bp.pred_hit     = rd_e.valid && rd_e.tag == if_tag;
   assign bp.pred_taken   = bp.pred_hit && rd_e.cnt >= wt(CNT_W);
   assign bp.pred_next_pc = bp.pred_taken ? rd_e.target : bp.if_pc + 32'd4;
   assign mis = bp.upd_valid && (bp.upd_taken != bp.upd_pred_taken ||
                                 (bp.upd_taken && bp.upd_target != bp.upd_pred_target));
   assign bp.mispredict = mis;
   assign bp.recover_pc = !bp.upd_valid ? 32'd0 : bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
   // A not-taken miss allocates nothing; a taken miss evicts whatever aliases at this index.
   assign up_hit = up_e.valid && up_e.tag == up_tag;
   assign wr_en  = bp.upd_valid && (up_hit || bp.upd_taken);
   assign wr_e   = up_hit
      ? bp_entry_t'{valid: 1'b1, tag: up_tag, target: bp.upd_taken ? bp.upd_target : up_e.target,
                    cnt: sat_step(up_e.cnt, bp.upd_taken, CNT_W)}
      : bp_entry_t'{valid: 1'b1, tag: up_tag, target: bp.upd_target, cnt: wt(CNT_W)};
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         n_br  <= '0;
         n_mis <= '0;
      end else begin
         if (bp.upd_valid && !(&n_br)) n_br <= n_br + PERF_W'(1);
         if (mis && !(&n_mis)) n_mis <= n_mis + PERF_W'(1);
      end
   assign bp.perf_branches = n_br;
   assign bp.perf_mispred  = n_mis;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table-driven directed vectors plus saturation and asynchronous-reset sequences.
module tb_branch_predictor;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;

   branch_predictor_if #(.PERF_W(4)) bpi();
   branch_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_W(2), .PERF_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bpi.slave)
   );

   typedef struct {
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        upt;
      logic [31:0] uptgt;
      logic [31:0] ipc;
      logic        e_hit;
      logic        e_tk;
      logic [31:0] e_next;
      logic        e_mis;
      logic [31:0] e_rec;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bpi.upd_valid       = v.uv;
      bpi.upd_pc          = v.upc;
      bpi.upd_taken       = v.ut;
      bpi.upd_target      = v.utgt;
      bpi.upd_pred_taken  = v.upt;
      bpi.upd_pred_target = v.uptgt;
      bpi.if_pc           = v.ipc;
   endtask

   vec_t vecs [20];
   vec_t idle;

   initial begin
      // Index 4 holds tag 0 for 0x00400010 and tag 1 for 0x00400050.
      vecs[0]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h00400010, 0, 0, 32'h00400014, 0, 32'h0};
      vecs[1]  = '{1, 32'h00400010, 1, 32'h00400040, 0, 32'h0, 32'h00400010, 0, 0, 32'h00400014, 1, 32'h00400040};
      vecs[2]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h00400010, 1, 1, 32'h00400040, 0, 32'h0};
      vecs[3]  = '{1, 32'h00400010, 0, 32'h0, 1, 32'h00400040, 32'h00400010, 1, 1, 32'h00400040, 1, 32'h00400014};
      vecs[4]  = '{1, 32'h00400010, 0, 32'h0, 0, 32'h0, 32'h00400010, 1, 0, 32'h00400014, 0, 32'h00400014};
      vecs[5]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h00400010, 1, 0, 32'h00400014, 0, 32'h0};
      vecs[6]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h00400050, 0, 0, 32'h00400054, 0, 32'h0};
      vecs[7]  = '{1, 32'h00400050, 1, 32'h00400100, 0, 32'h0, 32'h00400050, 0, 0, 32'h00400054, 1, 32'h00400100};
      vecs[8]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h00400010, 0, 0, 32'h00400014, 0, 32'h0};
      vecs[9]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h00400050, 1, 1, 32'h00400100, 0, 32'h0};
      vecs[10] = '{1, 32'h00400050, 1, 32'h00400080, 1, 32'h00400040, 32'h00400050, 1, 1, 32'h00400100, 1, 32'h00400080};
      vecs[11] = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h00400050, 1, 1, 32'h00400080, 0, 32'h0};
      vecs[12] = '{1, 32'h00400050, 1, 32'h00400080, 1, 32'h00400080, 32'h00400050, 1, 1, 32'h00400080, 0, 32'h00400080};
      vecs[13] = '{1, 32'h00400050, 0, 32'h0, 1, 32'h00400080, 32'h00400050, 1, 1, 32'h00400080, 1, 32'h00400054};
      vecs[14] = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h00400050, 1, 1, 32'h00400080, 0, 32'h0};
      vecs[15] = '{1, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 32'hFFFFFFFC, 0, 0, 32'h00000000, 0, 32'h00000000};
      vecs[16] = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'hFFFFFFFC, 0, 0, 32'h00000000, 0, 32'h0};
      vecs[17] = '{0, 32'h00000200, 1, 32'h00000300, 0, 32'h0, 32'h00000200, 0, 0, 32'h00000204, 0, 32'h0};
      vecs[18] = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h00000200, 0, 0, 32'h00000204, 0, 32'h0};
      vecs[19] = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h00400053, 1, 1, 32'h00400080, 0, 32'h0};
      idle = vecs[0];
      drive(idle);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_perf_br", 32'(bpi.perf_branches), 32'd0);
      chk("reset_perf_mis", 32'(bpi.perf_mispred), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i]);
         @(negedge clk);
         chk($sformatf("v%0d_hit", i), 32'(bpi.pred_hit), 32'(vecs[i].e_hit));
         chk($sformatf("v%0d_taken", i), 32'(bpi.pred_taken), 32'(vecs[i].e_tk));
         chk($sformatf("v%0d_next", i), bpi.pred_next_pc, vecs[i].e_next);
         chk($sformatf("v%0d_mis", i), 32'(bpi.mispredict), 32'(vecs[i].e_mis));
         chk($sformatf("v%0d_rec", i), bpi.recover_pc, vecs[i].e_rec);
         @(posedge clk);
         #1;
      end
      drive(idle);
      @(negedge clk);
      chk("perf_br_table", 32'(bpi.perf_branches), 32'd8);
      chk("perf_mis_table", 32'(bpi.perf_mispred), 32'd5);
      // 20 mispredicting updates push both 4-bit counters to saturation.
      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         drive('{1, 32'h00000300, 1, 32'h00000400, 0, 32'h0, 32'h00000300, 0, 0, 32'h0, 0, 32'h0});
         @(negedge clk);
         chk($sformatf("sat%0d_mis", i), 32'(bpi.mispredict), 32'd1);
         @(posedge clk);
         #1;
      end
      drive(idle);
      bpi.if_pc = 32'h00000300;
      @(negedge clk);
      chk("sat_perf_br", 32'(bpi.perf_branches), 32'd15);
      chk("sat_perf_mis", 32'(bpi.perf_mispred), 32'd15);
      chk("sat_hit", 32'(bpi.pred_hit), 32'd1);
      chk("sat_next", bpi.pred_next_pc, 32'h00000400);
      @(posedge clk);
      #1;
      chk("sat_hold_br", 32'(bpi.perf_branches), 32'd15);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("async_perf_br", 32'(bpi.perf_branches), 32'd0);
      chk("async_perf_mis", 32'(bpi.perf_mispred), 32'd0);
      chk("async_hit", 32'(bpi.pred_hit), 32'd0);
      chk("async_next", bpi.pred_next_pc, 32'h00000304);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
